// File: rtl/hero_pkg.sv
// Shared types and screen geometry for the hero motion controller and its bomb timer.
package hero_pkg;

  typedef enum logic [1:0] {
    B_IDLE,
    B_FUSE,
    B_BLAST
  } bomb_state_t;

  localparam int X_PIXELS    = 635;
  localparam int Y_PIXELS    = 475;
  localparam int CHAR_HALF_X = 13;
  localparam int CHAR_HALF_Y = 28;
  localparam int BOMB_HALF   = 10;

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/hero_motion_ctrl_if.sv
// Key/collision inputs and position/bomb outputs shared between the hero controller and the level renderers.
interface hero_motion_ctrl_if;

  logic       frame_tick;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic       f_key;
  logic       coll;
  logic [9:0] char_pos_x;
  logic [9:0] char_pos_y;
  logic [9:0] bomb_pos_x;
  logic [9:0] bomb_pos_y;
  logic [3:0] b_cnt;

  modport master (
    output frame_tick, key_left, key_right, key_up, key_down, f_key, coll,
    input  char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y, b_cnt
  );

  modport slave (
    input  frame_tick, key_left, key_right, key_up, key_down, f_key, coll,
    output char_pos_x, char_pos_y, bomb_pos_x, bomb_pos_y, b_cnt
  );

endinterface

// File: rtl/hero_bomb_timer.sv
// Bomb FSM: arms on an f_key rising edge, counts fuse frames, then holds the explosion phase.
module hero_bomb_timer #(
  parameter int BOMB_TICKS     = 30,
  parameter int EXPLODE_CNT    = 3,
  parameter int EXPLODE_FRAMES = 20,
  parameter int BOMB_DY        = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       f_key,
  input  logic [9:0] char_pos_x,
  input  logic [9:0] char_pos_y,
  output logic [9:0] bomb_pos_x,
  output logic [9:0] bomb_pos_y,
  output logic [3:0] b_cnt
);
  import hero_pkg::*;

  localparam logic [7:0] FUSE_LAST  = 8'(BOMB_TICKS - 1);
  localparam logic [7:0] BLAST_LAST = 8'(EXPLODE_FRAMES - 1);
  localparam logic [3:0] CNT_BLAST  = 4'(EXPLODE_CNT);
  localparam logic [9:0] DY         = 10'(BOMB_DY);

  bomb_state_t state;
  logic        f_key_q;
  logic [7:0]  frame_cnt;

  // Edges outside B_IDLE fall through untouched, so a held or repeated key never re-arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= B_IDLE;
      f_key_q    <= 1'b0;
      frame_cnt  <= '0;
      b_cnt      <= '0;
      bomb_pos_x <= '0;
      bomb_pos_y <= '0;
    end else begin
      f_key_q <= f_key;
      case (state)
        B_IDLE: begin
          if (f_key && !f_key_q) begin
            bomb_pos_x <= char_pos_x;
            bomb_pos_y <= char_pos_y + DY;
            b_cnt      <= 4'd1;
            frame_cnt  <= '0;
            state      <= B_FUSE;
          end
        end
        B_FUSE: begin
          if (frame_tick) begin
            if (frame_cnt == FUSE_LAST) begin
              frame_cnt <= '0;
              b_cnt     <= b_cnt + 4'd1;
              if (b_cnt + 4'd1 == CNT_BLAST)
                state <= B_BLAST;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        B_BLAST: begin
          if (frame_tick) begin
            if (frame_cnt == BLAST_LAST) begin
              frame_cnt <= '0;
              b_cnt     <= '0;
              state     <= B_IDLE;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hero_motion_ctrl.sv
// Hero movement with per-frame collision revert and screen-edge guards; bomb handled by hero_bomb_timer.
// Optional HERO_GRAVITY_EN: hero falls unless key_up lifts it, key_down is ignored.
module hero_motion_ctrl #(
  parameter int START_X        = 320,
  parameter int START_Y        = 200,
  parameter int STEP           = 2,
  parameter int BOMB_TICKS     = 30,
  parameter int EXPLODE_CNT    = 3,
  parameter int EXPLODE_FRAMES = 20,
  parameter int BOMB_DY        = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  hero_motion_ctrl_if.slave  bus
);
  import hero_pkg::*;

  localparam logic [9:0]  START_X_V  = 10'(START_X);
  localparam logic [9:0]  START_Y_V  = 10'(START_Y);
  localparam logic [9:0]  STEP_V     = 10'(STEP);
  localparam logic [10:0] LEFT_MIN   = 11'(STEP + CHAR_HALF_X + 1);
  localparam logic [10:0] RIGHT_ADD  = 11'(STEP + CHAR_HALF_X);
  localparam logic [10:0] RIGHT_MAX  = 11'(X_PIXELS - 1);
  localparam logic [10:0] TOP_MIN    = 11'(STEP + CHAR_HALF_Y + 1);
  localparam logic [10:0] BOTTOM_ADD = 11'(STEP + CHAR_HALF_Y);
  localparam logic [10:0] BOTTOM_MAX = 11'(Y_PIXELS - 1);

  logic [9:0] char_x, char_y;
  logic [9:0] prev_x, prev_y;
  logic [9:0] next_x, next_y;
  logic       coll_seen;
  logic       go_left, go_right, go_up, go_down;
  logic       left_ok, right_ok, up_ok, down_ok;

  assign go_left  = bus.key_left  && !bus.key_right;
  assign go_right = bus.key_right && !bus.key_left;
`ifdef HERO_GRAVITY_EN
  assign go_up    = bus.key_up;
  assign go_down  = !bus.key_up;
`else
  assign go_up    = bus.key_up   && !bus.key_down;
  assign go_down  = bus.key_down && !bus.key_up;
`endif

  // Edge tests are rearranged so no term can go negative in the 11-bit compare.
  assign left_ok  = ext11(char_x) >= LEFT_MIN;
  assign right_ok = ext11(char_x) + RIGHT_ADD <= RIGHT_MAX;
  assign up_ok    = ext11(char_y) >= TOP_MIN;
  assign down_ok  = ext11(char_y) + BOTTOM_ADD <= BOTTOM_MAX;

  always_comb begin
    next_x = char_x;
    next_y = char_y;
    if (go_right && right_ok)
      next_x = char_x + STEP_V;
    else if (go_left && left_ok)
      next_x = char_x - STEP_V;
    if (go_down && down_ok)
      next_y = char_y + STEP_V;
    else if (go_up && up_ok)
      next_y = char_y - STEP_V;
  end

  // A collision seen anywhere in the ending frame, including on the tick itself, undoes the last move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_x    <= START_X_V;
      char_y    <= START_Y_V;
      prev_x    <= START_X_V;
      prev_y    <= START_Y_V;
      coll_seen <= 1'b0;
    end else if (bus.frame_tick) begin
      coll_seen <= 1'b0;
      if (coll_seen || bus.coll) begin
        char_x <= prev_x;
        char_y <= prev_y;
      end else begin
        prev_x <= char_x;
        prev_y <= char_y;
        char_x <= next_x;
        char_y <= next_y;
      end
    end else if (bus.coll) begin
      coll_seen <= 1'b1;
    end
  end

  assign bus.char_pos_x = char_x;
  assign bus.char_pos_y = char_y;

  hero_bomb_timer #(
    .BOMB_TICKS     (BOMB_TICKS),
    .EXPLODE_CNT    (EXPLODE_CNT),
    .EXPLODE_FRAMES (EXPLODE_FRAMES),
    .BOMB_DY        (BOMB_DY)
  ) u_bomb (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (bus.frame_tick),
    .f_key      (bus.f_key),
    .char_pos_x (char_x),
    .char_pos_y (char_y),
    .bomb_pos_x (bus.bomb_pos_x),
    .bomb_pos_y (bus.bomb_pos_y),
    .b_cnt      (bus.b_cnt)
  );

endmodule

// File: tb/tb_hero_motion_ctrl.sv
// Directed bench for hero_motion_ctrl: movement, collision revert, edge guards, bomb timing and async reset.
module tb_hero_motion_ctrl;

  logic clk;
  logic rst_n;
  int   test_count;
  int   fail_count;

  hero_motion_ctrl_if bus ();

  hero_motion_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic u, input logic d);
    bus.key_left  = l;
    bus.key_right = r;
    bus.key_up    = u;
    bus.key_down  = d;
  endtask

  // Each tick is one cycle high followed by one idle cycle; called and returning on a falling edge.
  task automatic frameTick(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_count     = 0;
    fail_count     = 0;
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.f_key      = 1'b0;
    bus.coll       = 1'b0;
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_x", bus.char_pos_x, 320);
    checkOutput("reset_y", bus.char_pos_y, 200);
    checkOutput("reset_bx", bus.bomb_pos_x, 0);
    checkOutput("reset_by", bus.bomb_pos_y, 0);
    checkOutput("reset_bcnt", bus.b_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef HERO_GRAVITY_EN
    frameTick(5);
    checkOutput("grav_fall_y", bus.char_pos_y, 210);
    checkOutput("grav_fall_x", bus.char_pos_x, 320);
    applyStimulus(0, 0, 1, 0);
    frameTick(5);
    checkOutput("grav_lift_y", bus.char_pos_y, 200);
    applyStimulus(0, 0, 0, 1);
    frameTick(5);
    checkOutput("grav_down_ignored_y", bus.char_pos_y, 210);
    applyStimulus(0, 0, 0, 0);
`else
    applyStimulus(0, 1, 0, 0);
    frameTick(3);
    checkOutput("right3_x", bus.char_pos_x, 326);
    checkOutput("right3_y", bus.char_pos_y, 200);

    bus.coll = 1'b1;
    @(negedge clk);
    bus.coll = 1'b0;
    @(negedge clk);
    frameTick(1);
    checkOutput("coll_revert_x", bus.char_pos_x, 324);
    frameTick(1);
    checkOutput("after_revert_x", bus.char_pos_x, 326);

    bus.coll       = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.coll       = 1'b0;
    bus.frame_tick = 1'b0;
    @(negedge clk);
    checkOutput("coll_on_tick_x", bus.char_pos_x, 324);
    frameTick(1);
    checkOutput("coll_cleared_x", bus.char_pos_x, 326);

    applyStimulus(1, 1, 0, 0);
    frameTick(1);
    checkOutput("lr_cancel_x", bus.char_pos_x, 326);
    applyStimulus(0, 0, 1, 1);
    frameTick(1);
    checkOutput("ud_cancel_y", bus.char_pos_y, 200);

    applyStimulus(0, 0, 1, 0);
    frameTick(5);
    checkOutput("up5_y", bus.char_pos_y, 190);
    applyStimulus(0, 0, 0, 1);
    frameTick(5);
    checkOutput("down5_y", bus.char_pos_y, 200);

    applyStimulus(0, 0, 1, 0);
    frameTick(85);
    checkOutput("top_reach_y", bus.char_pos_y, 30);
    frameTick(1);
    checkOutput("top_guard_y", bus.char_pos_y, 30);
    applyStimulus(0, 0, 0, 1);
    frameTick(85);
    checkOutput("top_return_y", bus.char_pos_y, 200);

    applyStimulus(1, 0, 0, 0);
    frameTick(155);
    checkOutput("left_reach16_x", bus.char_pos_x, 16);
    frameTick(1);
    checkOutput("left_reach14_x", bus.char_pos_x, 14);
    frameTick(1);
    checkOutput("left_guard_x", bus.char_pos_x, 14);
    applyStimulus(0, 1, 0, 0);
    frameTick(153);
    checkOutput("right_back_x", bus.char_pos_x, 320);
    applyStimulus(0, 0, 0, 0);

    bus.f_key = 1'b1;
    @(negedge clk);
    checkOutput("arm_bx", bus.bomb_pos_x, 320);
    checkOutput("arm_by", bus.bomb_pos_y, 218);
    checkOutput("arm_bcnt", bus.b_cnt, 1);
    frameTick(29);
    checkOutput("fuse29_bcnt", bus.b_cnt, 1);
    bus.f_key = 1'b0;
    frameTick(1);
    checkOutput("fuse30_bcnt", bus.b_cnt, 2);

    bus.f_key = 1'b1;
    @(negedge clk);
    bus.f_key = 1'b0;
    @(negedge clk);
    checkOutput("rearm_ignored_bcnt", bus.b_cnt, 2);
    checkOutput("rearm_ignored_bx", bus.bomb_pos_x, 320);

    applyStimulus(0, 1, 0, 0);
    frameTick(3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("frozen_char_x", bus.char_pos_x, 326);
    checkOutput("frozen_bx", bus.bomb_pos_x, 320);
    checkOutput("frozen_by", bus.bomb_pos_y, 218);
    frameTick(27);
    checkOutput("blast60_bcnt", bus.b_cnt, 3);
    frameTick(19);
    checkOutput("blast79_bcnt", bus.b_cnt, 3);

    bus.frame_tick = 1'b1;
    bus.f_key      = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    checkOutput("blast80_bcnt", bus.b_cnt, 0);
    @(negedge clk);
    checkOutput("edge_on_last_ignored_bcnt", bus.b_cnt, 0);
    bus.f_key = 1'b0;
    @(negedge clk);

    bus.f_key = 1'b1;
    @(negedge clk);
    checkOutput("arm2_bx", bus.bomb_pos_x, 326);
    checkOutput("arm2_by", bus.bomb_pos_y, 218);
    bus.f_key = 1'b0;
    frameTick(30);
    checkOutput("arm2_fuse30_bcnt", bus.b_cnt, 2);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_bcnt", bus.b_cnt, 0);
    checkOutput("async_rst_x", bus.char_pos_x, 320);
    checkOutput("async_rst_y", bus.char_pos_y, 200);
    checkOutput("async_rst_bx", bus.bomb_pos_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frameTick(1);
    checkOutput("post_rst_bcnt", bus.b_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
